// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Contains:
//   state_t     - controller microstates, one per clock
//   alu_class_t - how the ALU decoder picks the ALU operation
//   ctrl_t      - Moore control word produced by each microstate
//   opcode / funct values, ALU operation codes, and the alusrcb,
//   pcsrc and ltype mux encodings used by the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
  } state_t;

  // AC_FUNCT defers the choice to the R-type funct field.
  typedef enum logic [2:0] {
    AC_NONE,
    AC_ADD,
    AC_SUB,
    AC_DADD,
    AC_AND,
    AC_OR,
    AC_FUNCT
  } alu_class_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LD    = 6'b110111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SD    = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_DADDI = 6'b011000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_DADD = 6'b101100;
  localparam logic [5:0] FN_DSUB = 6'b101110;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_DADD = 4'b1010;
  localparam logic [3:0] ALU_DSUB = 4'b1110;

  // ALU B-operand select
  localparam logic [2:0] SRCB_REGB       = 3'd0;
  localparam logic [2:0] SRCB_FOUR       = 3'd1;
  localparam logic [2:0] SRCB_SIGNIMM    = 3'd2;
  localparam logic [2:0] SRCB_SIGNIMM_SH = 3'd3;
  localparam logic [2:0] SRCB_ZEROIMM    = 3'd4;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Load data formatting
  localparam logic [1:0] LTYPE_FULL    = 2'd0;
  localparam logic [1:0] LTYPE_BYTE_ZX = 2'd1;
  localparam logic [1:0] LTYPE_BYTE_SX = 2'd2;

  typedef struct packed {
    logic       pcwrite;
    logic       branch_eq;
    logic       branch_ne;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       dtype;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    alu_class_t alu_class;
    logic [1:0] ltype;
  } ctrl_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LD) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder for the multicycle MIPS controller.
// Ports:
//   alu_class     in  operation class chosen by the current microstate
//   funct         in  R-type funct field (registered copy)
//   alucontrol    out ALU operation code
//   funct_illegal out high when alu_class is AC_FUNCT and funct is unsupported
module mips_multicycle_ctrl_aludec
  import mips_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  funct,
  output logic [3:0]  alucontrol,
  output logic        funct_illegal
);

  always_comb begin
    alucontrol    = ALU_AND;
    funct_illegal = 1'b0;
    case (alu_class)
      AC_ADD:  alucontrol = ALU_ADD;
      AC_SUB:  alucontrol = ALU_SUB;
      AC_DADD: alucontrol = ALU_DADD;
      AC_AND:  alucontrol = ALU_AND;
      AC_OR:   alucontrol = ALU_OR;
      AC_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          FN_DADD: alucontrol = ALU_DADD;
          FN_DSUB: alucontrol = ALU_DSUB;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the 64-bit multicycle MIPS datapath.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op, funct             instruction opcode and funct fields
//   zero                  ALU zero flag, current cycle
//   pcen                  PC enable (pcwrite or taken branch)
//   irwrite, memwrite, regwrite, dtype, iord, memtoreg, regdst,
//   alusrca, alusrcb, pcsrc, alucontrol, ltype
//                         datapath strobes, Moore outputs of the microstate
//   illegal               one-cycle pulse for an unsupported op/funct
//   retired               retired-instruction counter, wraps mod 2^CNTW
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  output logic            pcen,
  output logic            irwrite,
  output logic            memwrite,
  output logic            regwrite,
  output logic            dtype,
  output logic            iord,
  output logic            memtoreg,
  output logic            regdst,
  output logic            alusrca,
  output logic [2:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [3:0]      alucontrol,
  output logic [1:0]      ltype,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  state_t          state_q, state_d;
  logic [5:0]      op_q, op_d;
  logic [5:0]      funct_q, funct_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] retired_q, retired_d;

  ctrl_t      ctrl;
  ctrl_t      ctrl_out;
  logic [3:0] aludec_alucontrol;
  logic       funct_illegal;
  logic       retire;

  // Control word per microstate. Everything here depends only on the
  // state and the op/funct captured on leaving DECODE.
  always_comb begin
    ctrl           = '0;
    ctrl.alu_class = AC_NONE;
    case (state_q)
      S_FETCH: begin
        ctrl.irwrite   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.alu_class = AC_ADD;
        ctrl.pcsrc     = PCSRC_ALU;
        ctrl.pcwrite   = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb   = SRCB_SIGNIMM_SH;
        ctrl.alu_class = AC_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_SIGNIMM;
        ctrl.alu_class = AC_ADD;
      end
      S_MEMRD: begin
        ctrl.iord  = 1'b1;
        ctrl.dtype = (op_q == OP_LD);
        if (op_q == OP_LBU)
          ctrl.ltype = LTYPE_BYTE_ZX;
        else if (op_q == OP_LB)
          ctrl.ltype = LTYPE_BYTE_SX;
        else
          ctrl.ltype = LTYPE_FULL;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.dtype    = (op_q == OP_SD);
      end
      S_RTYPEEX: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_REGB;
        ctrl.alu_class = AC_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_REGB;
        ctrl.alu_class = AC_SUB;
        ctrl.pcsrc     = PCSRC_ALUOUT;
        ctrl.branch_eq = (op_q == OP_BEQ);
        ctrl.branch_ne = (op_q == OP_BNE);
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        ctrl.alusrcb = ((op_q == OP_ANDI) || (op_q == OP_ORI)) ? SRCB_ZEROIMM : SRCB_SIGNIMM;
        case (op_q)
          OP_DADDI: ctrl.alu_class = AC_DADD;
          OP_ANDI:  ctrl.alu_class = AC_AND;
          OP_ORI:   ctrl.alu_class = AC_OR;
          default:  ctrl.alu_class = AC_ADD;
        endcase
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  mips_multicycle_ctrl_aludec u_aludec (
    .alu_class     (ctrl.alu_class),
    .funct         (funct_q),
    .alucontrol    (aludec_alucontrol),
    .funct_illegal (funct_illegal)
  );

  // Next-state logic. op/funct are captured only while in DECODE so that
  // later microstates ignore anything that happens on the op/funct inputs.
  // An illegal instruction raises illegal_d, which shows up as a one-cycle
  // pulse during the FETCH that follows.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d    = op;
        funct_d = funct;
        if (is_load(op) || is_store(op))
          state_d = S_MEMADR;
        else begin
          case (op)
            OP_RTYPE:                           state_d = S_RTYPEEX;
            OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
            OP_ADDI, OP_DADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
            OP_J:                               state_d = S_JUMP;
            default: begin
              illegal_d = 1'b1;
              state_d   = S_FETCH;
            end
          endcase
        end
      end
      S_MEMADR: state_d = is_store(op_q) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTYPEEX: begin
        if (funct_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else
          state_d = S_RTYPEWB;
      end
      S_IMMEX: state_d = S_IMMWB;
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_BRANCH, S_IMMWB, S_JUMP: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNTW'(1) : retired_q;
  end

  // The controller's single state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // While reset is held every output reads 0, even though the state
  // register already sits in FETCH.
  assign ctrl_out   = reset ? '0 : ctrl;
  assign pcen       = ctrl_out.pcwrite | (ctrl_out.branch_eq & zero) | (ctrl_out.branch_ne & ~zero);
  assign irwrite    = ctrl_out.irwrite;
  assign memwrite   = ctrl_out.memwrite;
  assign regwrite   = ctrl_out.regwrite;
  assign dtype      = ctrl_out.dtype;
  assign iord       = ctrl_out.iord;
  assign memtoreg   = ctrl_out.memtoreg;
  assign regdst     = ctrl_out.regdst;
  assign alusrca    = ctrl_out.alusrca;
  assign alusrcb    = ctrl_out.alusrcb;
  assign pcsrc      = ctrl_out.pcsrc;
  assign ltype      = ctrl_out.ltype;
  assign alucontrol = reset ? 4'b0000 : aludec_alucontrol;
  assign illegal    = reset ? 1'b0 : illegal_q;
  assign retired    = reset ? '0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl, built with a 4-bit
// retired counter so the wrap-around case is reachable quickly.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, regwrite, dtype, iord;
  logic       memtoreg, regdst, alusrca;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic [1:0] ltype;
  logic       illegal;
  logic [3:0] retired;

  int compare_count = 0;
  int fail_count    = 0;

  mips_multicycle_ctrl #(.CNTW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .dtype      (dtype),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .ltype      (ltype),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op_v, input logic [5:0] funct_v, input logic zero_v);
    op    = op_v;
    funct = funct_v;
    zero  = zero_v;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One complete j instruction starting from FETCH.
  task automatic runJump();
    applyStimulus(6'b000010, 6'b000000, 1'b0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;
    $display("[TB] start");

    tick();
    tick();
    checkOutput("rst_irwrite", 32'(irwrite), 32'd0);
    checkOutput("rst_pcen",    32'(pcen),    32'd0);
    checkOutput("rst_retired", 32'(retired), 32'd0);

    reset = 1'b0;
    #1;
    checkOutput("fetch_irwrite", 32'(irwrite),    32'd1);
    checkOutput("fetch_alusrcb", 32'(alusrcb),    32'd1);
    checkOutput("fetch_alu",     32'(alucontrol), 32'd2);
    checkOutput("fetch_pcen",    32'(pcen),       32'd1);

    // lw: FETCH DECODE MEMADR MEMRD MEMWB; op changes after DECODE are ignored
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    tick();
    checkOutput("dec_alusrcb", 32'(alusrcb), 32'd3);
    checkOutput("dec_irwrite", 32'(irwrite), 32'd0);
    tick();
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    checkOutput("lw_memadr_srcb", 32'(alusrcb), 32'd2);
    checkOutput("lw_memadr_srca", 32'(alusrca), 32'd1);
    tick();
    checkOutput("lw_memrd_iord",     32'(iord),     32'd1);
    checkOutput("lw_memrd_memwrite", 32'(memwrite), 32'd0);
    checkOutput("lw_memrd_ltype",    32'(ltype),    32'd0);
    checkOutput("lw_memrd_dtype",    32'(dtype),    32'd0);
    tick();
    checkOutput("lw_memwb_regwrite", 32'(regwrite), 32'd1);
    checkOutput("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
    checkOutput("lw_memwb_retired",  32'(retired),  32'd0);
    tick();
    checkOutput("lw_done_irwrite", 32'(irwrite), 32'd1);
    checkOutput("lw_done_retired", 32'(retired), 32'd1);

    // lb: byte sign-extended load
    applyStimulus(6'b100000, 6'b000000, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("lb_memrd_ltype", 32'(ltype), 32'd2);
    tick();
    tick();
    checkOutput("lb_done_retired", 32'(retired), 32'd2);

    // beq: taken on zero=1
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    tick();
    tick();
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    checkOutput("beq_z1_pcen",  32'(pcen),       32'd1);
    checkOutput("beq_pcsrc",    32'(pcsrc),      32'd1);
    checkOutput("beq_alu",      32'(alucontrol), 32'd6);
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    checkOutput("beq_z0_pcen",  32'(pcen),       32'd0);
    tick();
    checkOutput("beq_done_irwrite", 32'(irwrite), 32'd1);
    checkOutput("beq_done_retired", 32'(retired), 32'd3);

    // bne: taken on zero=0
    applyStimulus(6'b000101, 6'b000000, 1'b0);
    tick();
    tick();
    applyStimulus(6'b000101, 6'b000000, 1'b1);
    checkOutput("bne_z1_pcen", 32'(pcen), 32'd0);
    applyStimulus(6'b000101, 6'b000000, 1'b0);
    checkOutput("bne_z0_pcen", 32'(pcen), 32'd1);
    tick();
    checkOutput("bne_done_irwrite", 32'(irwrite), 32'd1);
    checkOutput("bne_done_retired", 32'(retired), 32'd4);

    // R-type dsub; funct changes after DECODE are ignored
    applyStimulus(6'b000000, 6'b101110, 1'b0);
    tick();
    tick();
    checkOutput("dsub_alu",     32'(alucontrol), 32'd14);
    checkOutput("dsub_alusrca", 32'(alusrca),    32'd1);
    checkOutput("dsub_alusrcb", 32'(alusrcb),    32'd0);
    applyStimulus(6'b000000, 6'b111111, 1'b0);
    tick();
    checkOutput("dsub_wb_regwrite", 32'(regwrite), 32'd1);
    checkOutput("dsub_wb_regdst",   32'(regdst),   32'd1);
    tick();
    checkOutput("dsub_done_retired", 32'(retired), 32'd5);
    checkOutput("dsub_done_illegal", 32'(illegal), 32'd0);

    // R-type with unsupported funct
    applyStimulus(6'b000000, 6'b111111, 1'b0);
    tick();
    tick();
    checkOutput("badfn_ex_regwrite", 32'(regwrite), 32'd0);
    tick();
    checkOutput("badfn_illegal", 32'(illegal), 32'd1);
    checkOutput("badfn_irwrite", 32'(irwrite), 32'd1);
    checkOutput("badfn_retired", 32'(retired), 32'd5);

    // ori
    applyStimulus(6'b001101, 6'b000000, 1'b0);
    tick();
    checkOutput("ori_dec_illegal", 32'(illegal), 32'd0);
    tick();
    checkOutput("ori_alusrcb", 32'(alusrcb),    32'd4);
    checkOutput("ori_alu",     32'(alucontrol), 32'd1);
    tick();
    checkOutput("ori_wb_regwrite", 32'(regwrite), 32'd1);
    checkOutput("ori_wb_regdst",   32'(regdst),   32'd0);
    tick();
    checkOutput("ori_done_retired", 32'(retired), 32'd6);

    // j
    applyStimulus(6'b000010, 6'b000000, 1'b0);
    tick();
    tick();
    checkOutput("j_pcsrc", 32'(pcsrc), 32'd2);
    checkOutput("j_pcen",  32'(pcen),  32'd1);
    tick();
    checkOutput("j_done_retired", 32'(retired), 32'd7);

    // Unknown opcode
    applyStimulus(6'b010001, 6'b000000, 1'b0);
    tick();
    checkOutput("badop_dec_illegal", 32'(illegal), 32'd0);
    tick();
    checkOutput("badop_illegal", 32'(illegal), 32'd1);
    checkOutput("badop_irwrite", 32'(irwrite), 32'd1);
    checkOutput("badop_retired", 32'(retired), 32'd7);

    // sw interrupted by a two-cycle reset in MEMWR
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("sw_memwr_memwrite", 32'(memwrite), 32'd1);
    checkOutput("sw_memwr_iord",     32'(iord),     32'd1);
    checkOutput("sw_memwr_dtype",    32'(dtype),    32'd0);
    reset = 1'b1;
    tick();
    checkOutput("midrst_memwrite", 32'(memwrite), 32'd0);
    checkOutput("midrst_retired",  32'(retired),  32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("postrst_irwrite",  32'(irwrite),  32'd1);
    checkOutput("postrst_alusrcb",  32'(alusrcb),  32'd1);
    checkOutput("postrst_memwrite", 32'(memwrite), 32'd0);
    checkOutput("postrst_retired",  32'(retired),  32'd0);

    // Drive the 4-bit counter to all-ones, then one more j wraps it
    for (int i = 0; i < 15; i++) runJump();
    checkOutput("wrap_pre_retired", 32'(retired), 32'd15);
    runJump();
    checkOutput("wrap_retired", 32'(retired), 32'd0);
    checkOutput("wrap_irwrite", 32'(irwrite), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
